// File: rtl/pkg_hamming.sv
// -----------------------------------------------------------------------------
// pkg_hamming
//   Shared types and constants for the Hamming(8,4) SECDED receive sequencer.
//   estado_t    : sequencer states
//   SIN_ERROR   : syndrome/parity word for "no error"
//   MSK_PARIDAD : selects the overall-parity mismatch bit of pos_error
// -----------------------------------------------------------------------------
package pkg_hamming;

   typedef enum logic [2:0] {
      REPOSO,
      CAPTURA,
      ESPERA,
      REGISTRO,
      MOSTRAR
   } estado_t;

   localparam logic [3:0] SIN_ERROR   = 4'b0000;
   localparam logic [3:0] MSK_PARIDAD = 4'b1000;

endpackage

// File: rtl/antirrebote.sv
// -----------------------------------------------------------------------------
// antirrebote
//   Two-flop synchroniser, debounce filter and rising-edge pulse generator for
//   the capture push-button.
//   Parameters:
//     DEBOUNCE_CYC : cycles the synced level must differ from the accepted
//                    level before the change is accepted
//   Ports:
//     clk   in  system clock
//     rst   in  asynchronous reset, active-high
//     btn   in  raw push-button, asynchronous, active-high
//     pulso out one-cycle pulse on an accepted 0->1 transition
// -----------------------------------------------------------------------------
module antirrebote #(
   parameter int DEBOUNCE_CYC = 270_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulso
);

   localparam int              DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [DB_W-1:0] DB_FIN = DB_W'(DEBOUNCE_CYC - 1);

   logic            btn_s1;
   logic            btn_s2;
   logic            nivel;     // accepted (debounced) level
   logic            armado;    // a released level has been accepted since reset
   logic            pendiente;
   logic [DB_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours (the synchroniser depends on it).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
      end else begin
         btn_s1 <= btn;
         btn_s2 <= btn_s1;
      end
   end

   // A button held through reset must not fire: until a released level has
   // been debounced, the filter also runs on a synced 0 just to arm itself.
   assign pendiente = (btn_s2 != nivel) || (!armado && !btn_s2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         nivel  <= 1'b0;
         armado <= 1'b0;
         pulso  <= 1'b0;
      end else begin
         pulso <= 1'b0;
         if (!pendiente) begin
            cnt <= '0;
         end else if (cnt == DB_FIN) begin
            cnt   <= '0;
            nivel <= btn_s2;
            if (btn_s2) pulso  <= armado;
            else        armado <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/control_decodificador.sv
// -----------------------------------------------------------------------------
// control_decodificador
//   Sequencer for the Hamming(8,4) SECDED receive path: debounces the capture
//   button, latches the switch word for the datapath, waits for it to settle
//   and registers the corrected nibble plus error class.
//   Optional feature macro: CONTROL_CONTADORES_EN (saturating error counters).
//   Parameters:
//     DEBOUNCE_CYC, SETTLE_CYC, CNT_W (CNT_W only with CONTROL_CONTADORES_EN)
//   Ports:
//     clk, rst        clock / asynchronous active-high reset
//     btn_capturar    raw capture button
//     conmutador_8    raw switch word
//     pos_error       [3] parity mismatch, [2:0] syndrome (from datapath)
//     w_corregida_b4  [3:0] corrected data, [4] double-error flag (from datapath)
//     palabra_reg     latched word driven to the datapath
//     w_resultado     registered corrected nibble
//     error_simple    registered single-error flag
//     error_doble     registered double-error flag
//     listo           one-cycle pulse when results are updated
//     ocupado         high while capturing / settling
//     cnt_simple, cnt_doble  saturating error counters (optional)
// -----------------------------------------------------------------------------
module control_decodificador
   import pkg_hamming::*;
#(
   parameter int DEBOUNCE_CYC = 270_000,
   parameter int SETTLE_CYC   = 2
`ifdef CONTROL_CONTADORES_EN
   , parameter int CNT_W      = 8
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_capturar,
   input  logic [7:0] conmutador_8,
   input  logic [3:0] pos_error,
   input  logic [4:0] w_corregida_b4,
   output logic [7:0] palabra_reg,
   output logic [3:0] w_resultado,
   output logic       error_simple,
   output logic       error_doble,
   output logic       listo,
   output logic       ocupado
`ifdef CONTROL_CONTADORES_EN
   , output logic [CNT_W-1:0] cnt_simple,
   output logic [CNT_W-1:0] cnt_doble
`endif
);

   localparam int               SET_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SET_W-1:0] SET_FIN = SET_W'(SETTLE_CYC - 1);

   estado_t          estado, estado_sig;
   logic             pulso;
   logic [7:0]       sw_s1, sw_s2;
   logic [SET_W-1:0] espera_cnt;
   logic             es_simple, es_doble;

   antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_antirrebote (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_capturar),
      .pulso (pulso)
   );

   // Error class as presented by the datapath. The syndrome pattern for a
   // double error (parity clean, syndrome non-zero) is folded in; for a real
   // decoder it always agrees with the correction block's own flag.
   assign es_simple = (pos_error & MSK_PARIDAD) != SIN_ERROR;
   assign es_doble  = w_corregida_b4[4] |
                      (((pos_error & MSK_PARIDAD) == SIN_ERROR) && (pos_error != SIN_ERROR));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= conmutador_8;
         sw_s2 <= sw_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) estado <= REPOSO;
      else     estado <= estado_sig;
   end

   // NOTE: every signal written here is given a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      estado_sig = estado;
      listo      = 1'b0;
      ocupado    = 1'b0;
      case (estado)
         REPOSO:   if (pulso) estado_sig = CAPTURA;
         CAPTURA: begin
            ocupado    = 1'b1;
            estado_sig = ESPERA;
         end
         ESPERA: begin
            // A pulse arriving here is dropped, not remembered.
            ocupado = 1'b1;
            if (espera_cnt == SET_FIN) estado_sig = REGISTRO;
         end
         REGISTRO: begin
            listo      = 1'b1;
            estado_sig = MOSTRAR;
         end
         MOSTRAR:  if (pulso) estado_sig = CAPTURA;
         default:  estado_sig = REPOSO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         palabra_reg  <= '0;
         w_resultado  <= '0;
         error_simple <= 1'b0;
         error_doble  <= 1'b0;
         espera_cnt   <= '0;
      end else begin
         case (estado)
            CAPTURA: begin
               palabra_reg <= sw_s2;
               espera_cnt  <= '0;
            end
            ESPERA:  espera_cnt <= espera_cnt + 1'b1;
            REGISTRO: begin
               w_resultado  <= w_corregida_b4[3:0];
               error_simple <= es_simple;
               error_doble  <= es_doble;
            end
            default: ;
         endcase
      end
   end

`ifdef CONTROL_CONTADORES_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_simple <= '0;
         cnt_doble  <= '0;
      end else if (estado == REGISTRO) begin
         if (es_simple && !(&cnt_simple)) cnt_simple <= cnt_simple + 1'b1;
         if (es_doble  && !(&cnt_doble))  cnt_doble  <= cnt_doble  + 1'b1;
      end
   end
`else
   // Error counters not built.
`endif

endmodule

// File: tb/tb_control_decodificador.sv
// -----------------------------------------------------------------------------
// tb_control_decodificador
//   Self-checking bench for control_decodificador (DEBOUNCE_CYC=4,
//   SETTLE_CYC=2). The datapath is stood in for by bench-driven pos_error /
//   w_corregida_b4 values; expected results come from a transaction-level
//   model: each completed capture yields the word, nibble and flags it was
//   given, and the counters count matching flags up to all-ones.
// -----------------------------------------------------------------------------
module tb_control_decodificador;

   localparam int DEB = 4;
   localparam int SET = 2;
   localparam int CNT_MAX = 255;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_capturar = 1'b0;
   logic [7:0] conmutador_8 = '0;
   logic [3:0] pos_error = '0;
   logic [4:0] w_corregida_b4 = '0;
   logic [7:0] palabra_reg;
   logic [3:0] w_resultado;
   logic       error_simple, error_doble, listo, ocupado;
`ifdef CONTROL_CONTADORES_EN
   logic [7:0] cnt_simple, cnt_doble;
`endif

   control_decodificador #(.DEBOUNCE_CYC(DEB), .SETTLE_CYC(SET)) dut (
      .clk            (clk),
      .rst            (rst),
      .btn_capturar   (btn_capturar),
      .conmutador_8   (conmutador_8),
      .pos_error      (pos_error),
      .w_corregida_b4 (w_corregida_b4),
      .palabra_reg    (palabra_reg),
      .w_resultado    (w_resultado),
      .error_simple   (error_simple),
      .error_doble    (error_doble),
      .listo          (listo),
      .ocupado        (ocupado)
`ifdef CONTROL_CONTADORES_EN
      , .cnt_simple   (cnt_simple),
      .cnt_doble      (cnt_doble)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Event monitor, sampled on the falling edge.
   int cyc = 0, listo_cnt = 0, listo_cyc = 0, occ_rise_cyc = 0;
   bit ocupado_q = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (listo === 1'b1) begin
         listo_cnt++;
         listo_cyc = cyc;
      end
      if (ocupado === 1'b1 && !ocupado_q) occ_rise_cyc = cyc;
      ocupado_q = (ocupado === 1'b1);
   end

   // Reference model of the externally visible result registers.
   logic [7:0] m_palabra = '0;
   logic [3:0] m_res = '0;
   bit         m_es = 1'b0, m_ed = 1'b0;
   int         m_cs = 0, m_cd = 0;
   int         base_listo = 0;

   // ocupado rises in the cycle after pulso, so pulso->listo of 1+SET+1
   // cycles appears as SET+1 cycles from the rise of ocupado.
   localparam int LAT_OCUPADO = SET + 1;

   // Press, wait (bounded) for listo, release and let the release debounce.
   task automatic run_capture(input logic [7:0] sw, input logic [3:0] pe,
                              input logic [4:0] wc, input bit cambiar_sw,
                              output bit ok);
      conmutador_8   = sw;
      pos_error      = pe;
      w_corregida_b4 = wc;
      repeat (3) @(negedge clk);
      base_listo   = listo_cnt;
      btn_capturar = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cambiar_sw && ocupado === 1'b1) conmutador_8 = 8'($urandom);
         if (listo_cnt != base_listo) begin
            ok = 1'b1;
            break;
         end
      end
      btn_capturar = 1'b0;
      repeat (12) @(negedge clk);
      m_palabra = sw;
      m_res     = wc[3:0];
      m_es      = pe[3];
      m_ed      = wc[4];
      if (pe[3] && m_cs < CNT_MAX) m_cs++;
      if (wc[4] && m_cd < CNT_MAX) m_cd++;
   endtask

   task automatic test_reset;
      n_cmp++;
      if ({palabra_reg, w_resultado, error_simple, error_doble, listo, ocupado} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h expected 0000",
                  {palabra_reg, w_resultado, error_simple, error_doble, listo, ocupado});
      end
   endtask

   task automatic test_capture(input string nm, input logic [7:0] sw,
                               input logic [3:0] pe, input logic [4:0] wc);
      bit ok;
      run_capture(sw, pe, wc, 1'b0, ok);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s_timeout: no listo within 40 cycles", nm);
      end
      n_cmp++;
      if (listo_cyc - occ_rise_cyc !== LAT_OCUPADO) begin
         n_err++;
         $display("FAIL %s_latency: got %0d expected %0d", nm, listo_cyc - occ_rise_cyc, LAT_OCUPADO);
      end
      n_cmp++;
      if (listo_cnt - base_listo !== 1) begin
         n_err++;
         $display("FAIL %s_listo_count: got %0d expected 1", nm, listo_cnt - base_listo);
      end
      n_cmp++;
      if ({palabra_reg, w_resultado, error_simple, error_doble, ocupado}
          !== {m_palabra, m_res, m_es, m_ed, 1'b0}) begin
         n_err++;
         $display("FAIL %s_outputs: got pal=%b res=%b es=%b ed=%b oc=%b expected pal=%b res=%b es=%b ed=%b oc=0",
                  nm, palabra_reg, w_resultado, error_simple, error_doble, ocupado,
                  m_palabra, m_res, m_es, m_ed);
      end
   endtask

   task automatic test_rebote;
      int n0;
      conmutador_8   = 8'b0101_1010;
      pos_error      = 4'b0000;
      w_corregida_b4 = 5'b0_0101;
      repeat (3) @(negedge clk);
      n0 = listo_cnt;
      btn_capturar = 1'b1; repeat (2) @(negedge clk);
      btn_capturar = 1'b0; repeat (2) @(negedge clk);
      btn_capturar = 1'b1; repeat (20) @(negedge clk);
      btn_capturar = 1'b0; repeat (15) @(negedge clk);
      m_palabra = 8'b0101_1010; m_res = 4'b0101; m_es = 1'b0; m_ed = 1'b0;
      n_cmp++;
      if (listo_cnt - n0 !== 1) begin
         n_err++;
         $display("FAIL rebote_captures: got %0d expected 1", listo_cnt - n0);
      end
      n_cmp++;
      if ({palabra_reg, w_resultado} !== {m_palabra, m_res}) begin
         n_err++;
         $display("FAIL rebote_data: got %h expected %h", {palabra_reg, w_resultado}, {m_palabra, m_res});
      end
   endtask

   task automatic test_press_in_espera;
      int n0;
      bit seen = 1'b0;
      conmutador_8   = 8'b0011_1100;
      pos_error      = 4'b1100;
      w_corregida_b4 = 5'b0_0011;
      repeat (3) @(negedge clk);
      n0 = listo_cnt;
      btn_capturar = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (ocupado === 1'b1) seen = 1'b1;
      end
      // Release and press again while the sequencer is busy.
      @(negedge clk); btn_capturar = 1'b0;
      @(negedge clk); btn_capturar = 1'b1;
      @(negedge clk); btn_capturar = 1'b0;
      repeat (30) @(negedge clk);
      m_palabra = 8'b0011_1100; m_res = 4'b0011; m_es = 1'b1; m_ed = 1'b0;
      if (m_cs < CNT_MAX) m_cs++;
      n_cmp++;
      if (listo_cnt - n0 !== 1 || ocupado !== 1'b0) begin
         n_err++;
         $display("FAIL espera_press: got listo=%0d ocupado=%b expected listo=1 ocupado=0",
                  listo_cnt - n0, ocupado);
      end
      n_cmp++;
      if ({palabra_reg, w_resultado, error_simple} !== {m_palabra, m_res, m_es}) begin
         n_err++;
         $display("FAIL espera_data: got %h expected %h",
                  {palabra_reg, w_resultado, error_simple}, {m_palabra, m_res, m_es});
      end
   endtask

   task automatic test_reset_in_espera;
      int n0;
      bit seen = 1'b0;
      conmutador_8   = 8'b1111_0000;
      pos_error      = 4'b0110;
      w_corregida_b4 = 5'b1_1001;
      repeat (3) @(negedge clk);
      n0 = listo_cnt;
      btn_capturar = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (ocupado === 1'b1) seen = 1'b1;
      end
      @(negedge clk);           // first ESPERA cycle
      rst = 1'b1;
      #1;
      m_palabra = '0; m_res = '0; m_es = 1'b0; m_ed = 1'b0; m_cs = 0; m_cd = 0;
      n_cmp++;
      if ({palabra_reg, w_resultado, error_simple, error_doble, listo, ocupado} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_espera_outputs: got %h expected 0000",
                  {palabra_reg, w_resultado, error_simple, error_doble, listo, ocupado});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      // Button still held: must not be taken as a press.
      repeat (25) @(negedge clk);
      n_cmp++;
      if (listo_cnt !== n0 || ocupado !== 1'b0) begin
         n_err++;
         $display("FAIL held_through_reset: got listo=%0d ocupado=%b expected listo=0 ocupado=0",
                  listo_cnt - n0, ocupado);
      end
      btn_capturar = 1'b0;
      repeat (12) @(negedge clk);
      test_capture("after_reset", 8'b1010_0110, 4'b1010, 5'b0_1100);
   endtask

   task automatic test_aleatorio;
      for (int k = 0; k < 12; k++) begin
         logic [7:0] sw;
         logic [3:0] pe;
         logic [4:0] wc;
         bit ok;
         sw = 8'($urandom);
         pe = 4'($urandom);
         wc[4]   = !pe[3] && (pe[2:0] != 3'b000);
         wc[3:0] = (pe == 4'b0000) ? sw[7:4] : 4'($urandom);
         // Switches wiggle once the capture has started.
         run_capture(sw, pe, wc, 1'b1, ok);
         n_cmp++;
         if (!ok || listo_cnt - base_listo !== 1 || listo_cyc - occ_rise_cyc !== LAT_OCUPADO) begin
            n_err++;
            $display("FAIL rand%0d_timing: ok=%b listo=%0d lat=%0d expected ok=1 listo=1 lat=%0d",
                     k, ok, listo_cnt - base_listo, listo_cyc - occ_rise_cyc, LAT_OCUPADO);
         end
         n_cmp++;
         if ({palabra_reg, w_resultado, error_simple, error_doble}
             !== {m_palabra, m_res, m_es, m_ed}) begin
            n_err++;
            $display("FAIL rand%0d_outputs: got %b expected %b", k,
                     {palabra_reg, w_resultado, error_simple, error_doble},
                     {m_palabra, m_res, m_es, m_ed});
         end
`ifdef CONTROL_CONTADORES_EN
         n_cmp++;
         if ({cnt_simple, cnt_doble} !== {8'(m_cs), 8'(m_cd)}) begin
            n_err++;
            $display("FAIL rand%0d_counters: got %0d/%0d expected %0d/%0d",
                     k, cnt_simple, cnt_doble, m_cs, m_cd);
         end
`endif
      end
   endtask

`ifdef CONTROL_CONTADORES_EN
   task automatic test_saturacion;
      bit ok;
      for (int k = 0; k < 300; k++)
         run_capture(8'($urandom), 4'b1000, {1'b0, 4'($urandom)}, 1'b0, ok);
      n_cmp++;
      if ({cnt_simple, cnt_doble} !== {8'(m_cs), 8'(m_cd)} || cnt_simple !== 8'd255) begin
         n_err++;
         $display("FAIL saturacion: got %0d/%0d expected %0d/%0d",
                  cnt_simple, cnt_doble, m_cs, m_cd);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      repeat (12) @(negedge clk);
      test_reset();
      test_capture("sin_error",    8'b1110_0001, 4'b0000, 5'b0_1110);
      test_capture("error_simple", 8'b1110_0101, 4'b1011, 5'b0_1110);
      test_capture("error_doble",  8'b1000_0001, 4'b0001, 5'b1_1000);
      test_rebote();
      test_press_in_espera();
      test_reset_in_espera();
      test_aleatorio();
`ifdef CONTROL_CONTADORES_EN
      test_saturacion();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
